// File: rtl/pend_pkg.sv
// Shared definitions for the request pending tracker.
// Also holds the encoder code to source index mapping.
package pend_pkg;

  localparam int N_SRC     = 4;
  localparam int CNT_W_DEF = 3;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  function automatic logic [1:0] idx_to_src(input logic [1:0] k);
    return 2'd3 - k;
  endfunction

endpackage

// File: rtl/pend_cnt_cell.sv
// Single saturating up/down pending counter.
// Flags overflow and underflow attempts; never wraps.
module pend_cnt_cell #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             ovf_set_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Simultaneous inc and dec cancel out, so neither flag fires.
  always_comb begin
    cnt_d     = cnt_q;
    ovf_set_o = 1'b0;
    err_o     = 1'b0;
    unique case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q == MAX) ovf_set_o = 1'b1;
        else              cnt_d     = cnt_q + ONE;
      end
      2'b01: begin
        if (cnt_q == '0) err_o = 1'b1;
        else             cnt_d = cnt_q - ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;

endmodule

// File: rtl/req_pend_tracker.sv
// Per-source pending counters feeding the priority encoder.
// Encoder results come back as service strobes.
module req_pend_tracker
  import pend_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_in,
  input  logic               srv_valid,
  input  logic [1:0]         srv_idx,
  input  logic               ovf_clr,
  output logic [3:0]         D,
  output logic [4*CNT_W-1:0] pend_cnt,
  output logic [3:0]         ovf,
  output logic               srv_err
);

  logic [N_SRC-1:0] dec;
  logic [N_SRC-1:0] ovf_set;
  logic [N_SRC-1:0] err;
  logic [N_SRC-1:0] nz_d;

  logic [N_SRC-1:0] d_q;
  logic [N_SRC-1:0] ovf_q;
  logic             err_q;

  always_comb begin
    dec = '0;
    if (srv_valid) dec[idx_to_src(srv_idx)] = 1'b1;
  end

  for (genvar i = 0; i < N_SRC; i++) begin : g_cell
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;

    pend_cnt_cell #(.CNT_W(CNT_W)) u_cell (
      .clk_i     (clk),
      .rst_i     (rst),
      .inc_i     (req_in[i]),
      .dec_i     (dec[i]),
      .cnt_o     (cnt),
      .cnt_d_o   (cnt_d),
      .ovf_set_o (ovf_set[i]),
      .err_o     (err[i])
    );

    assign nz_d[i] = (cnt_d != '0);
    assign pend_cnt[i*CNT_W +: CNT_W] = cnt;
  end

  // A fresh overflow wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q   <= '0;
      ovf_q <= '0;
      err_q <= 1'b0;
    end else begin
      d_q   <= nz_d;
      ovf_q <= (ovf_q & ~{N_SRC{ovf_clr}}) | ovf_set;
      err_q <= |err;
    end
  end

  assign D       = d_q;
  assign ovf     = ovf_q;
  assign srv_err = err_q;

endmodule

// File: tb/tb_req_pend_tracker.sv
// Self-checking bench: directed steps, random traffic
// and a closed service loop against a behavioural model.
module tb_req_pend_tracker;

  localparam int CW  = 3;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_in;
  logic          srv_valid;
  logic [1:0]    srv_idx;
  logic          ovf_clr;
  logic [3:0]    D;
  logic [4*CW-1:0] pend_cnt;
  logic [3:0]    ovf;
  logic          srv_err;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_cnt[4];
  bit m_ovf[4];
  bit m_err;

  always #5 clk = ~clk;

  req_pend_tracker #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .srv_valid (srv_valid),
    .srv_idx   (srv_idx),
    .ovf_clr   (ovf_clr),
    .D         (D),
    .pend_cnt  (pend_cnt),
    .ovf       (ovf),
    .srv_err   (srv_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt_vec();
    int v = 0;
    for (int i = 0; i < 4; i++) v += m_cnt[i] << (i * CW);
    return v;
  endfunction

  function automatic int exp_d();
    int v = 0;
    for (int i = 0; i < 4; i++) if (m_cnt[i] != 0) v += 1 << i;
    return v;
  endfunction

  function automatic int exp_ovf();
    int v = 0;
    for (int i = 0; i < 4; i++) if (m_ovf[i]) v += 1 << i;
    return v;
  endfunction

  task automatic model_step();
    bit e = 0;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0;
        m_ovf[i] = 0;
      end
      m_err = 0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      bit inc = req_in[i];
      bit dc  = srv_valid && (3 - int'(srv_idx) == i);
      bit set = 0;
      if (inc && !dc) begin
        if (m_cnt[i] < MAX) m_cnt[i]++;
        else set = 1;
      end else if (dc && !inc) begin
        if (m_cnt[i] > 0) m_cnt[i]--;
        else e = 1;
      end
      m_ovf[i] = (m_ovf[i] && !ovf_clr) || set;
    end
    m_err = e;
  endtask

  task automatic cyc(input logic [3:0] r, input logic sv,
                     input logic [1:0] si, input logic clr,
                     input logic rs);
    req_in    = r;
    srv_valid = sv;
    srv_idx   = si;
    ovf_clr   = clr;
    rst       = rs;
    @(posedge clk);
    model_step();
    #1;
    chk("pend_cnt", int'(pend_cnt), exp_cnt_vec());
    chk("D", int'(D), exp_d());
    chk("ovf", int'(ovf), exp_ovf());
    chk("srv_err", int'(srv_err), int'(m_err));
  endtask

  int served[$];
  bit err_seen;
  logic [3:0] dv;

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 0;
    end
    m_err = 0;
    req_in = '0; srv_valid = 0; srv_idx = '0; ovf_clr = 0; rst = 1;
    #2;

    // 1: reset, idle, reset with nonzero counts
    cyc(4'h0, 0, 2'd0, 0, 1);
    repeat (3) cyc(4'h0, 0, 2'd0, 0, 0);
    chk("rst_D", int'(D), 0);
    chk("rst_cnt", int'(pend_cnt), 0);
    cyc(4'hF, 0, 2'd0, 0, 0);
    cyc(4'hF, 0, 2'd0, 0, 0);
    cyc(4'h0, 0, 2'd0, 0, 1);
    chk("rst_mid_cnt", int'(pend_cnt), 0);
    chk("rst_mid_D", int'(D), 0);

    // 2: count up and serve source 0
    cyc(4'b0001, 0, 2'd0, 0, 0);
    chk("s0_first_D", int'(D), 4'b0001);
    cyc(4'b0001, 0, 2'd0, 0, 0);
    chk("s0_cnt2", int'(pend_cnt[CW-1:0]), 2);
    cyc(4'b0000, 1, 2'd3, 0, 0);
    chk("s0_cnt1", int'(pend_cnt[CW-1:0]), 1);
    cyc(4'b0000, 1, 2'd3, 0, 0);
    chk("s0_cnt0", int'(pend_cnt[CW-1:0]), 0);
    chk("s0_D0", int'(D), 0);

    // 3: saturate source 2, then clear overflow
    repeat (9) cyc(4'b0100, 0, 2'd0, 0, 0);
    chk("sat_cnt2", int'(pend_cnt[2*CW +: CW]), 7);
    chk("sat_ovf", int'(ovf), 4'b0100);
    cyc(4'b0000, 0, 2'd0, 1, 0);
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_cnt2", int'(pend_cnt[2*CW +: CW]), 7);
    cyc(4'b0100, 0, 2'd0, 1, 0);
    chk("set_wins", int'(ovf), 4'b0100);
    cyc(4'b0100, 1, 2'd1, 0, 0);
    chk("max_incdec_hold", int'(pend_cnt[2*CW +: CW]), 7);

    // 4: inc and dec together on source 3
    cyc(4'h0, 0, 2'd0, 0, 1);
    cyc(4'b1000, 0, 2'd0, 0, 0);
    cyc(4'b1000, 1, 2'd0, 0, 0);
    chk("incdec_cnt3", int'(pend_cnt[3*CW +: CW]), 1);
    chk("incdec_D3", int'(D[3]), 1);
    chk("incdec_err", int'(srv_err), 0);
    cyc(4'b0010, 1, 2'd2, 0, 0);
    chk("zero_incdec_err", int'(srv_err), 0);
    chk("zero_incdec_cnt1", int'(pend_cnt[CW +: CW]), 0);

    // 5: service on empty source 1
    cyc(4'b0000, 1, 2'd2, 0, 0);
    chk("uflow_err", int'(srv_err), 1);
    chk("uflow_cnt1", int'(pend_cnt[CW +: CW]), 0);
    cyc(4'b0000, 0, 2'd2, 0, 0);
    chk("uflow_err_pulse", int'(srv_err), 0);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      logic [3:0] r;
      logic [1:0] si;
      r  = 4'($urandom);
      si = 2'($urandom);
      cyc(r & 4'($urandom), ($urandom_range(0, 2) == 0), si,
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 60) == 0));
    end

    // 6: closed loop, lowest source index has priority
    cyc(4'h0, 0, 2'd0, 0, 1);
    cyc(4'b1011, 0, 2'd0, 0, 0);
    cyc(4'b0010, 0, 2'd0, 0, 0);
    err_seen = 0;
    for (int it = 0; it < 16; it++) begin
      dv = D;
      if (dv == 4'h0) break;
      for (int i = 0; i < 4; i++) begin
        if (dv[i]) begin
          served.push_back(i);
          cyc(4'h0, 1, 2'(3 - i), 0, 0);
          break;
        end
      end
      if (srv_err) err_seen = 1;
      cyc(4'h0, 0, 2'd0, 0, 0);
      if (srv_err) err_seen = 1;
    end
    chk("loop_n", served.size(), 4);
    if (served.size() == 4) begin
      chk("loop_0", served[0], 0);
      chk("loop_1", served[1], 1);
      chk("loop_2", served[2], 1);
      chk("loop_3", served[3], 3);
    end
    chk("loop_D", int'(D), 0);
    chk("loop_err", int'(err_seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
